// File: rtl/avalon_uart_pkg.sv
// Shared types and constants for the Avalon command arbiter and the requesters that sit on it.
package avalon_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Register map seen by the requesters through the master port.
  localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;
  localparam logic [31:0] REG_TXDATA = 32'h0000_0008;
  localparam logic [31:0] REG_RXDATA = 32'h0000_000C;

  // Round-robin pick between two requesters; a tie goes to the channel that did not win last.
  function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last);
    logic win;
    win = CH_A;
    if (req_a && req_b) win = ~last;
    else if (req_b)     win = CH_B;
    return win;
  endfunction

endpackage

// File: rtl/avalon_cmd_arbiter_if.sv
// Bundle of the two requester channels and the shared master command port.
interface avalon_cmd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: req_x is a level held until done_x; done_x is a one-cycle pulse with err_x/rdata_x
  // valid in that cycle. start_m is a level held with a stable command until done_m is seen.
  logic              req_a;
  logic              rnw_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              done_a;
  logic              err_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              rnw_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              done_b;
  logic              err_b;
  logic [DATA_W-1:0] rdata_b;

  logic              start_m;
  logic              rnw_m;
  logic [ADDR_W-1:0] addr_m;
  logic [DATA_W-1:0] wdata_m;
  logic              done_m;
  logic [DATA_W-1:0] rdata_m;

  // Arbiter view: serves the requesters and drives the command towards the bus master.
  modport master (
    input  req_a, rnw_a, addr_a, wdata_a,
    output done_a, err_a, rdata_a,
    input  req_b, rnw_b, addr_b, wdata_b,
    output done_b, err_b, rdata_b,
    output start_m, rnw_m, addr_m, wdata_m,
    input  done_m, rdata_m
  );

  // Environment view: requesters plus the bus master responding to the command.
  modport slave (
    output req_a, rnw_a, addr_a, wdata_a,
    input  done_a, err_a, rdata_a,
    output req_b, rnw_b, addr_b, wdata_b,
    input  done_b, err_b, rdata_b,
    input  start_m, rnw_m, addr_m, wdata_m,
    output done_m, rdata_m
  );

endinterface

// File: rtl/avalon_cmd_arbiter_watchdog.sv
// Cycle counter that flags a transfer the master has left pending for TIMEOUT_CYCLES cycles.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused;
      assign unused    = clk_i ^ rst_i ^ clear_i ^ enable_i;
      assign expired_o = 1'b0;
    end else begin : g_enabled
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear_i)       cnt_d = '0;
        else if (enable_i) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      // Counter reads 0 in the first BUSY cycle, so this fires on the TIMEOUT_CYCLES-th one.
      assign expired_o = enable_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/avalon_cmd_arbiter.sv
// Two-channel round-robin arbiter in front of one Avalon-MM master command port.
module avalon_cmd_arbiter
  import avalon_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  avalon_cmd_arbiter_if.master bus,
  output logic                 busy,
  output logic                 owner,
  output arb_state_t           state_o
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              win;
  logic              wd_clear;
  logic              wd_en;
  logic              wd_expired;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    win      = CH_A;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          win      = rr_pick(bus.req_a, bus.req_b, owner_q);
          owner_d  = win;
          rnw_d    = (win == CH_A) ? bus.rnw_a   : bus.rnw_b;
          addr_d   = (win == CH_A) ? bus.addr_a  : bus.addr_b;
          wdata_d  = (win == CH_A) ? bus.wdata_a : bus.wdata_b;
          wd_clear = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        wd_en = 1'b1;
        // A completion in the expiry cycle still counts as a good transfer.
        if (bus.done_m) begin
          rdata_d = rnw_q ? bus.rdata_m : '0;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wd_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= CH_B;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  logic in_done;
  assign in_done = (state_q == DONE);

  assign bus.start_m = (state_q == BUSY);
  assign bus.rnw_m   = rnw_q;
  assign bus.addr_m  = addr_q;
  assign bus.wdata_m = wdata_q;

  assign bus.done_a  = in_done && (owner_q == CH_A);
  assign bus.err_a   = in_done && (owner_q == CH_A) && err_q;
  assign bus.rdata_a = (in_done && (owner_q == CH_A)) ? rdata_q : '0;
  assign bus.done_b  = in_done && (owner_q == CH_B);
  assign bus.err_b   = in_done && (owner_q == CH_B) && err_q;
  assign bus.rdata_b = (in_done && (owner_q == CH_B)) ? rdata_q : '0;

  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_avalon_cmd_arbiter.sv
// Directed bench for avalon_cmd_arbiter: responder tasks, a done-pulse scoreboard and a summary.
module tb_avalon_cmd_arbiter;
  import avalon_uart_pkg::*;

  localparam int TO = 16;
  localparam int W  = 4 + 2 * 32;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       busy;
  logic       owner;
  arb_state_t state_o;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_done   = -1;

  logic [W-1:0] exp_q[$];

  avalon_cmd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  avalon_cmd_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ADDR_W        (32),
    .DATA_W        (32)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .busy    (busy),
    .owner   (owner),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic ch, input logic err, input logic [31:0] rd);
    if (ch == CH_A) return {1'b1, 1'b0, err, 1'b0, rd, 32'h0};
    return {1'b0, 1'b1, 1'b0, err, 32'h0, rd};
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation; otherwise all zero.
  always @(negedge CLK) begin
    logic [W-1:0] obs;
    obs = {bus.done_a, bus.done_b, bus.err_a, bus.err_b, bus.rdata_a, bus.rdata_b};
    if (!RST) begin
      if (bus.done_a || bus.done_b) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", obs, '0);
        end else begin
          check("done_result", obs, exp_q.pop_front());
        end
        if (last_done >= 0) check("done_spacing", W'(cyc - last_done >= 4), W'(1));
        last_done = cyc;
      end else begin
        check("outputs_quiet", obs, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic req, input logic rnw, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_a = req; bus.rnw_a = rnw; bus.addr_a = addr; bus.wdata_a = wdata;
  endtask

  task automatic drive_b(input logic req, input logic rnw, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_b = req; bus.rnw_b = rnw; bus.addr_b = addr; bus.wdata_b = wdata;
  endtask

  // Bus master model: wait for start_m, hold it lat cycles checking the command, then answer.
  task automatic respond(input int lat, input logic [31:0] rd, input logic exp_rnw,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic exp_owner, input bit do_done, input bit scramble);
    int n = 0;
    @(negedge CLK);
    while (!bus.start_m && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("start_seen", W'(bus.start_m), W'(1));
    check("owner_on_grant", W'(owner), W'(exp_owner));
    for (int i = 1; i <= lat; i++) begin
      check("start_held", W'(bus.start_m), W'(1));
      check("rnw_m", W'(bus.rnw_m), W'(exp_rnw));
      check("addr_m", W'(bus.addr_m), W'(exp_addr));
      check("wdata_m", W'(bus.wdata_m), W'(exp_wdata));
      if (scramble && i == 2) begin
        bus.addr_a  = $urandom;
        bus.wdata_a = $urandom;
        bus.rnw_a   = ~bus.rnw_a;
      end
      if (do_done && i == lat) begin
        bus.done_m  = 1'b1;
        bus.rdata_m = rd;
      end
      @(negedge CLK);
    end
    bus.done_m  = 1'b0;
    bus.rdata_m = $urandom;
    check("start_dropped", W'(bus.start_m), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    bus.done_m  = 1'b0;
    bus.rdata_m = $urandom;
    repeat (2) @(negedge CLK);

    // Reset state
    check("rst_start_m", W'(bus.start_m), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_owner", W'(owner), W'(1));
    check("rst_state", W'(state_o), W'(IDLE));
    check("rst_addr_m", W'(bus.addr_m), W'(0));
    RST = 1'b0;

    // Single write on A, command inputs scrambled after grant
    drive_a(1'b1, 1'b0, REG_STATUS, 32'hDEAD_BEEF);
    exp_q.push_back(pack_exp(CH_A, 1'b0, 32'h0));
    respond(5, 32'hFFFF_0000, 1'b0, REG_STATUS, 32'hDEAD_BEEF, CH_A, 1'b1, 1'b1);
    bus.req_a = 1'b0;
    @(negedge CLK);
    check("gap_busy", W'(busy), W'(1));
    @(negedge CLK);
    check("idle_busy", W'(busy), W'(0));

    // Single read on B
    drive_b(1'b1, 1'b1, REG_RXDATA, 32'h5555_AAAA);
    exp_q.push_back(pack_exp(CH_B, 1'b0, 32'h0000_0041));
    respond($urandom_range(1, 6), 32'h0000_0041, 1'b1, REG_RXDATA, 32'h5555_AAAA, CH_B, 1'b1, 1'b0);
    bus.req_b = 1'b0;
    repeat (2) @(negedge CLK);

    // Both requests held from reset: A, B, A
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive_a(1'b1, 1'b0, REG_CTRL, 32'h1111_1111);
    drive_b(1'b1, 1'b1, REG_TXDATA, 32'h2222_2222);
    exp_q.push_back(pack_exp(CH_A, 1'b0, 32'h0));
    exp_q.push_back(pack_exp(CH_B, 1'b0, 32'h0000_0022));
    exp_q.push_back(pack_exp(CH_A, 1'b0, 32'h0));
    respond(1, 32'h0000_0099, 1'b0, REG_CTRL, 32'h1111_1111, CH_A, 1'b1, 1'b0);
    respond(1, 32'h0000_0022, 1'b1, REG_TXDATA, 32'h2222_2222, CH_B, 1'b1, 1'b0);
    respond(2, 32'h0000_0033, 1'b0, REG_CTRL, 32'h1111_1111, CH_A, 1'b1, 1'b0);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    repeat (2) @(negedge CLK);

    // Timeout: master never answers
    drive_a(1'b1, 1'b0, REG_TXDATA, 32'h0BAD_CAFE);
    exp_q.push_back(pack_exp(CH_A, 1'b1, 32'h0));
    respond(TO, 32'h0, 1'b0, REG_TXDATA, 32'h0BAD_CAFE, CH_A, 1'b0, 1'b0);
    bus.req_a = 1'b0;
    @(negedge CLK);
    check("to_gap_busy", W'(busy), W'(1));
    @(negedge CLK);
    check("to_idle_busy", W'(busy), W'(0));

    // done_m on the expiry cycle wins over the watchdog
    drive_a(1'b1, 1'b1, REG_STATUS, 32'h0);
    exp_q.push_back(pack_exp(CH_A, 1'b0, 32'hA5A5_0042));
    respond(TO, 32'hA5A5_0042, 1'b1, REG_STATUS, 32'h0, CH_A, 1'b1, 1'b0);
    bus.req_a = 1'b0;
    repeat (3) @(negedge CLK);

    // Stray done_m while idle
    bus.done_m  = 1'b1;
    bus.rdata_m = 32'h1234_5678;
    @(negedge CLK);
    bus.done_m  = 1'b0;
    check("stray_busy", W'(busy), W'(0));
    @(negedge CLK);
    check("stray_done_a", W'({bus.done_a, bus.done_b}), W'(0));

    // Reset in the middle of a transfer
    drive_a(1'b1, 1'b0, REG_CTRL, 32'h7777_7777);
    begin
      int n = 0;
      while (!bus.start_m && n < 20) begin
        @(negedge CLK);
        n++;
      end
    end
    check("mid_start_seen", W'(bus.start_m), W'(1));
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("mid_rst_start", W'(bus.start_m), W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_owner", W'(owner), W'(1));
    bus.req_a = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    drive_a(1'b1, 1'b0, REG_TXDATA, 32'h0000_00C3);
    exp_q.push_back(pack_exp(CH_A, 1'b0, 32'h0));
    respond(3, 32'hFFFF_FFFF, 1'b0, REG_TXDATA, 32'h0000_00C3, CH_A, 1'b1, 1'b0);
    bus.req_a = 1'b0;
    repeat (3) @(negedge CLK);

    // ---------------- report ----------------
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
